// File: rtl/ep_tx_inject_engine_pkg.sv
// Shared definitions for the TX packet-injection engine: template word layout,
// FSM state encoding and fixed fabric constants.
package ep_inject_pkg;

  localparam int unsigned c_TMPL_LAST  = 17;
  localparam int unsigned c_TMPL_SUBST = 16;
  localparam int unsigned c_TMPL_W     = 18;
  localparam int unsigned c_DAT_W      = 16;
  localparam int unsigned c_SLOT_W     = 3;

  localparam logic [1:0] c_WRF_DATA    = 2'b00;
  localparam logic [1:0] c_WRF_SEL_ALL = 2'b11;

  // Template word as stored in RAM: {last, substitute, data}
  typedef struct packed {
    logic                 last;
    logic                 subst;
    logic [c_DAT_W-1:0]   data;
  } t_tmpl_word;

  typedef logic [1:0] t_inject_state;
  localparam t_inject_state c_ST_IDLE  = 2'd0;
  localparam t_inject_state c_ST_PREP  = 2'd1;
  localparam t_inject_state c_ST_SEND  = 2'd2;
  localparam t_inject_state c_ST_DRAIN = 2'd3;

endpackage

// File: rtl/ep_tx_inject_engine_if.sv
// Pipelined Wishbone fabric link toward the TX framer.
//   master: dat/adr/sel/cyc/stb/we out, stall/ack/err in
//   slave : the reverse
interface ep_wrf_if;
  import ep_inject_pkg::*;

  logic [c_DAT_W-1:0] dat;
  logic [1:0]         adr;
  logic [1:0]         sel;
  logic               cyc;
  logic               stb;
  logic               we;
  logic               stall;
  logic               ack;
  logic               err;

  modport master (output dat, adr, sel, cyc, stb, we, input stall, ack, err);
  modport slave  (input dat, adr, sel, cyc, stb, we, output stall, ack, err);
endinterface

// File: rtl/ep_tx_inject_engine_tmpl_ram.sv
// Template store: simple dual-port RAM with one-cycle registered read.
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr -> o_rdata   : read data valid the cycle after the address
module ep_inject_tmpl_ram
  import ep_inject_pkg::*;
#(
  parameter int unsigned g_addr_w = 9
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [g_addr_w-1:0] i_waddr,
  input  logic [c_TMPL_W-1:0] i_wdata,
  input  logic [g_addr_w-1:0] i_raddr,
  output logic [c_TMPL_W-1:0] o_rdata
);

  localparam int unsigned c_DEPTH = 1 << g_addr_w;

  logic [c_TMPL_W-1:0] r_mem [c_DEPTH];
  logic [c_TMPL_W-1:0] r_rdata;

  // Storage array
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register, reset so the fabric data bus starts at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ep_tx_inject_engine.sv
// Packet-injection responder: on an accepted request plays one of 8 stored
// templates onto the fabric source, splicing the user value into flagged words.
//   inject_*  : request handshake from the host-side initiator
//   tmpl_*    : template write port, address = {slot, word index}
//   src       : fabric source (master modport)
module ep_tx_inject_engine
  import ep_inject_pkg::*;
#(
  parameter int unsigned g_template_words  = 64,
  parameter int unsigned g_max_outstanding = 16
) (
  input  logic                                             clk_sys_i,
  input  logic                                             rst_n_i,
  input  logic                                             inject_req_i,
  output logic                                             inject_ready_o,
  input  logic [c_SLOT_W-1:0]                              inject_packet_sel_i,
  input  logic [c_DAT_W-1:0]                               inject_user_value_i,
  output logic                                             inject_err_o,
  input  logic                                             tmpl_we_i,
  input  logic [c_SLOT_W+$clog2(g_template_words)-1:0]     tmpl_addr_i,
  input  logic [c_TMPL_W-1:0]                              tmpl_data_i,
  ep_wrf_if.master                                         src
);

  localparam int unsigned c_IDX_W  = $clog2(g_template_words);
  localparam int unsigned c_CNT_W  = $clog2(g_max_outstanding + 1);
  localparam int unsigned c_ADDR_W = c_SLOT_W + c_IDX_W;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(g_template_words - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(g_max_outstanding);

  t_inject_state        r_state;
  t_inject_state        w_state_nxt;
  logic [c_SLOT_W-1:0]  r_sel;
  logic [c_DAT_W-1:0]   r_user;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_err;

  logic [c_TMPL_W-1:0]  w_rdata;
  t_tmpl_word           w_word;
  logic [c_ADDR_W-1:0]  w_raddr;
  logic [c_IDX_W-1:0]   w_idx_inc;
  logic                 w_stb;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_fab_err;
  logic                 w_ack_eff;

  assign w_word    = t_tmpl_word'(w_rdata);
  assign w_stb     = (r_state == c_ST_SEND) && (r_cnt != c_CNT_MAX);
  assign w_accept  = w_stb && !src.stall;
  // Last word of the slot ends the frame even without the flag
  assign w_last    = w_word.last || (r_idx == c_IDX_LAST);
  assign w_fab_err = src.err && ((r_state == c_ST_SEND) || (r_state == c_ST_DRAIN));
  // Acks beyond the outstanding count are stray and dropped
  assign w_ack_eff = src.ack && (r_cnt != '0);
  assign w_idx_inc = r_idx + c_IDX_W'(1);

  // Read address runs ahead on accept so a word can go out every cycle
  assign w_raddr = {r_sel, (w_accept ? w_idx_inc : r_idx)};

  ep_inject_tmpl_ram #(
    .g_addr_w (c_ADDR_W)
  ) u_tmpl_ram (
    .i_clk   (clk_sys_i),
    .i_rst_n (rst_n_i),
    .i_we    (tmpl_we_i),
    .i_waddr (tmpl_addr_i),
    .i_wdata (tmpl_data_i),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= c_ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (inject_req_i) w_state_nxt = c_ST_PREP;
      c_ST_PREP:  w_state_nxt = c_ST_SEND;
      c_ST_SEND: begin
        if (w_fab_err)              w_state_nxt = c_ST_IDLE;
        else if (w_accept && w_last) w_state_nxt = c_ST_DRAIN;
      end
      c_ST_DRAIN: if (w_fab_err || (r_cnt == '0)) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Request capture and word index
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sel  <= '0;
      r_user <= '0;
      r_idx  <= '0;
    end else if ((r_state == c_ST_IDLE) && inject_req_i) begin
      r_sel  <= inject_packet_sel_i;
      r_user <= inject_user_value_i;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_idx  <= w_idx_inc;
    end
  end

  // Outstanding strobe counter and error pulse
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_fab_err;
      if (w_fab_err)                    r_cnt <= '0;
      else if (w_accept && !w_ack_eff)  r_cnt <= r_cnt + c_CNT_W'(1);
      else if (!w_accept && w_ack_eff)  r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  assign inject_ready_o = (r_state == c_ST_IDLE);
  assign inject_err_o   = r_err;

  // cyc drops for one cycle in DRAIN before ready returns
  assign src.cyc = (r_state == c_ST_SEND) || ((r_state == c_ST_DRAIN) && (r_cnt != '0));
  assign src.stb = w_stb;
  assign src.dat = (r_state == c_ST_SEND) ? (w_word.subst ? r_user : w_word.data) : '0;
  assign src.adr = c_WRF_DATA;
  assign src.sel = c_WRF_SEL_ALL;
  assign src.we  = 1'b1;

endmodule

// File: tb/tb_ep_tx_inject_engine.sv
// Self-checking bench for ep_tx_inject_engine with a randomized fabric sink
// and a frame-level reference model built from a shadow copy of the templates.
module tb_ep_tx_inject_engine;
  import ep_inject_pkg::*;

  localparam int unsigned c_W   = 64;
  localparam int unsigned c_MAX = 4;
  localparam int unsigned c_AW  = 3 + 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              ready;
  logic [2:0]        psel = '0;
  logic [15:0]       user = '0;
  logic              err_o;
  logic              twe = 1'b0;
  logic [c_AW-1:0]   taddr = '0;
  logic [17:0]       tdata = '0;

  ep_wrf_if src_if ();

  always #5 clk = ~clk;

  ep_tx_inject_engine #(
    .g_template_words  (c_W),
    .g_max_outstanding (c_MAX)
  ) dut (
    .clk_sys_i           (clk),
    .rst_n_i             (rst_n),
    .inject_req_i        (req),
    .inject_ready_o      (ready),
    .inject_packet_sel_i (psel),
    .inject_user_value_i (user),
    .inject_err_o        (err_o),
    .tmpl_we_i           (twe),
    .tmpl_addr_i         (taddr),
    .tmpl_data_i         (tdata),
    .src                 (src_if)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] usr;
    int          stall_pct;
    int          ack_lat;
    int          mode;     // 0 plain, 1 stall word 1, 2 acks withheld, 3 fabric error, 4 req held
    int          exp_len;
  } t_vec;

  logic [17:0] shadow [8][c_W];
  int          lens [8] = '{1, 7, 3, 10, 64, 64, 2, 33};
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int          ack_due [$];
  int          stall_pct = 0;
  int          ack_lat = 1;
  int          force_stall = 0;
  logic        ack_hold = 1'b0;
  logic        err_req = 1'b0;
  int          outst = 0;
  int          max_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // One clock of the fabric sink; inputs set here are sampled at the next rising edge
  task automatic step();
    @(negedge clk);
    cyc_cnt++;
    src_if.stall = (force_stall > 0) ? 1'b1 : (int'($urandom_range(99)) < stall_pct);
    if (force_stall > 0) force_stall--;
    src_if.err = err_req;
    err_req = 1'b0;
    if (!ack_hold && ack_due.size() > 0 && ack_due[0] <= cyc_cnt) begin
      src_if.ack = 1'b1;
      void'(ack_due.pop_front());
      if (outst > 0) outst--;
    end else begin
      src_if.ack = 1'b0;
    end
    if (src_if.cyc && src_if.stb && !src_if.stall) begin
      got_q.push_back(src_if.dat);
      ack_due.push_back(cyc_cnt + 1 + int'($urandom_range(ack_lat - 1)));
      outst++;
      if (outst > max_seen) max_seen = outst;
    end
  endtask

  // Expected frame: words up to the first last flag, at most one slot long
  task automatic build_exp(input logic [2:0] s, input logic [15:0] u);
    exp_q.delete();
    for (int i = 0; i < int'(c_W); i++) begin
      exp_q.push_back(shadow[s][i][16] ? u : shadow[s][i][15:0]);
      if (shadow[s][i][17]) break;
    end
  endtask

  task automatic run_frame(input t_vec v);
    int   guard;
    logic stall_done, hold_done, bad_hold;
    int   hold_left;
    build_exp(v.sel, v.usr);
    got_q.delete();
    max_seen   = outst;
    stall_pct  = v.stall_pct;
    ack_lat    = v.ack_lat;
    ack_hold   = (v.mode == 2);
    stall_done = 1'b0;
    hold_done  = 1'b0;
    hold_left  = 0;
    guard = 0;
    while (!ready && guard < 100) begin step(); guard++; end
    chk("ready_before_req", ready, 1);
    req = 1'b1; psel = v.sel; user = v.usr;
    step();
    if (v.mode != 4) req = 1'b0;
    chk("ready_drop", ready, 0);
    chk("prep_no_stb", src_if.stb, 0);
    step();
    chk("first_stb", src_if.stb, 1);
    guard = 0;
    while (guard < 3000) begin
      if (v.mode == 1 && !stall_done && got_q.size() == 1) begin
        force_stall = 4; hold_left = 4; stall_done = 1'b1;
      end
      if (v.mode == 2 && !hold_done && got_q.size() == c_MAX) begin
        step();
        chk("stb_drop_at_max", src_if.stb, 0);
        bad_hold = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          if (src_if.stb || got_q.size() != c_MAX) bad_hold = 1'b1;
        end
        chk("stb_held_low", bad_hold, 0);
        ack_hold = 1'b0; hold_done = 1'b1;
      end
      if (v.mode == 3 && got_q.size() == 2) begin
        force_stall = 1; err_req = 1'b1;
        step();
        step();
        chk("err_cyc_drop", src_if.cyc, 0);
        chk("err_pulse", err_o, 1);
        chk("err_ready", ready, 1);
        step();
        chk("err_pulse_end", err_o, 0);
        chk("err_words", got_q.size(), 2);
        ack_due.delete(); outst = 0; src_if.ack = 1'b0;
        return;
      end
      step();
      guard++;
      if (hold_left > 0) begin
        chk("stall_hold_dat", src_if.dat, v.usr);
        chk("stall_hold_stb", src_if.stb, 1);
        hold_left--;
      end
      if (!src_if.cyc) break;
    end
    req = 1'b0;
    chk("frame_done", src_if.cyc, 0);
    chk("ready_lag", ready, 0);
    step();
    chk("ready_back", ready, 1);
    chk("frame_len", got_q.size(), v.exp_len);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
    chk("max_outstanding", (max_seen <= int'(c_MAX)), 1);
    chk("acks_done", ack_due.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", ready, 1);
    chk("rst_cyc", src_if.cyc, 0);
    chk("rst_stb", src_if.stb, 0);
    chk("rst_dat", src_if.dat, 0);
    chk("rst_adr", src_if.adr, 0);
    chk("rst_sel", src_if.sel, 2'b11);
    chk("rst_we", src_if.we, 1);
    chk("rst_err", err_o, 0);
  endtask

  t_vec vecs [12];
  t_vec rv;

  initial begin
    src_if.stall = 1'b0; src_if.ack = 1'b0; src_if.err = 1'b0;
    vecs = '{
      '{3'd2, 16'hBEEF, 0,  1, 0, 3},
      '{3'd5, 16'h5A5A, 0,  1, 0, 64},
      '{3'd0, 16'h0F0F, 30, 3, 0, 1},
      '{3'd1, 16'hC001, 50, 2, 0, 7},
      '{3'd4, 16'h4444, 20, 5, 0, 64},
      '{3'd6, 16'h6666, 0,  1, 0, 2},
      '{3'd7, 16'h7777, 40, 4, 0, 33},
      '{3'd2, 16'hBEEF, 0,  1, 1, 3},
      '{3'd3, 16'h3A3A, 0,  1, 2, 10},
      '{3'd2, 16'hBEEF, 0,  1, 3, 3},
      '{3'd2, 16'hCAFE, 0,  1, 0, 3},
      '{3'd1, 16'h1234, 25, 3, 4, 7}
    };

    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Template load through the write port
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < int'(c_W); i++) begin
        tdata[15:0] = 16'($urandom);
        tdata[16]   = ($urandom_range(3) == 0);
        tdata[17]   = (s != 5) && (i == lens[s] - 1);
        if (s == 2 && i < 3) begin
          tdata = (i == 0) ? 18'h01111 : (i == 1) ? 18'h12222 : 18'h23333;
        end
        shadow[s][i] = tdata;
        taddr = {3'(s), 6'(i)};
        twe = 1'b1;
        step();
      end
    end
    twe = 1'b0;

    for (int k = 0; k < 12; k++) run_frame(vecs[k]);

    for (int k = 0; k < 6; k++) begin
      rv.sel       = 3'($urandom_range(7));
      rv.usr       = 16'($urandom);
      rv.stall_pct = int'($urandom_range(60));
      rv.ack_lat   = 1 + int'($urandom_range(5));
      rv.mode      = 0;
      rv.exp_len   = lens[rv.sel];
      run_frame(rv);
    end

    // Reset in the middle of a frame
    stall_pct = 0; ack_lat = 2;
    req = 1'b1; psel = 3'd7; user = 16'hDEAD;
    step();
    req = 1'b0;
    for (int g = 0; g < 100 && got_q.size() < 5; g++) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", src_if.cyc, 0);
    chk("async_rst_stb", src_if.stb, 0);
    @(negedge clk);
    chk_reset_vals();
    got_q.delete(); ack_due.delete(); outst = 0;
    src_if.ack = 1'b0; src_if.stall = 1'b0;
    rst_n = 1'b1;
    rv = '{3'd7, 16'hF00D, 10, 2, 0, 33};
    run_frame(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
